// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes (also used by the ALU control decoder)
// and the execute-unit FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] fn);
        return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response handshake bundle between the issue stage, the execute ALU
// and the writeback/branch consumer.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_function;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_function, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_function, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_shift_serial.sv
// Iterative one-bit-per-cycle shifter: working register plus down-counter.
// data_nxt is the value the register takes at the next edge while busy.
module alu_shift_serial #(
    parameter int XLEN = 32,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            left,
    input  logic            arith,
    input  logic [XLEN-1:0] data_in,
    input  logic [SHW-1:0]  shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] data_nxt
);
    logic [XLEN-1:0] data_q, data_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;

    assign busy = (cnt_q != {SHW{1'b0}});
    // The cycle holding count 1 performs the final shift.
    assign done = (cnt_q == SHW'(1));

    // One-bit shift of the working register in the latched direction.
    always_comb begin
        if (left_q) begin
            data_nxt = {data_q[XLEN-2:0], 1'b0};
        end else begin
            data_nxt = {arith_q & data_q[XLEN-1], data_q[XLEN-1:1]};
        end
    end

    // Load / step control for register and counter.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load) begin
            data_d  = data_in;
            cnt_d   = shamt;
            left_d  = left;
            arith_d = arith;
        end else if (busy) begin
            data_d = data_nxt;
            cnt_d  = cnt_q - SHW'(1);
        end else begin
            cnt_d = {SHW{1'b0}};
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {XLEN{1'b0}};
            cnt_q   <= {SHW{1'b0}};
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, serial shifts, and a
// held result on a valid/ready output handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_exec_unit_if.slave    bus
);
    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] alu_res_s;
    logic            alu_illegal_s;
    logic [SHW-1:0]  shamt_s;
    logic            sh_load_s;
    logic            sh_busy_s;
    logic            sh_done_s;
    logic [XLEN-1:0] sh_nxt_s;

    assign shamt_s = bus.op_b[SHW-1:0];

    alu_shift_serial #(.XLEN(XLEN)) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load_s),
        .left     (bus.alu_function == ALU_SLL),
        .arith    (bus.alu_function == ALU_SRA),
        .data_in  (bus.op_a),
        .shamt    (shamt_s),
        .busy     (sh_busy_s),
        .done     (sh_done_s),
        .data_nxt (sh_nxt_s)
    );

    // Single-cycle datapath for the non-shift codes.
    always_comb begin
        alu_res_s     = {XLEN{1'b0}};
        alu_illegal_s = 1'b0;
        case (bus.alu_function)
            ALU_AND: alu_res_s = bus.op_a & bus.op_b;
            ALU_OR:  alu_res_s = bus.op_a | bus.op_b;
            ALU_ADD: alu_res_s = bus.op_a + bus.op_b;
            ALU_SUB: alu_res_s = bus.op_a - bus.op_b;
            ALU_SLT: alu_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res_s = {XLEN{1'b0}};
            default: alu_illegal_s = 1'b1;
        endcase
    end

    // FSM next-state and result capture.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        sh_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.in_valid) begin
                    state_d = ST_IDLE;
                end else if (is_shift(bus.alu_function)) begin
                    illegal_d = 1'b0;
                    if (shamt_s == {SHW{1'b0}}) begin
                        result_d = bus.op_a;
                        zero_d   = (bus.op_a == {XLEN{1'b0}});
                        state_d  = ST_DONE;
                    end else begin
                        sh_load_s = 1'b1;
                        state_d   = ST_SHIFT;
                    end
                end else begin
                    result_d  = alu_res_s;
                    zero_d    = (alu_res_s == {XLEN{1'b0}});
                    illegal_d = alu_illegal_s;
                    state_d   = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (sh_done_s) begin
                    result_d = sh_nxt_s;
                    zero_d   = (sh_nxt_s == {XLEN{1'b0}});
                    state_d  = ST_DONE;
                end else if (!sh_busy_s) begin
                    // Counter emptied without a final step: abandon rather than stall.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= {XLEN{1'b0}};
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule
